// File: rtl/ldst_mem_responder_if.sv
// Load/store port bundle between a compiled kernel (master) and its memory
// responder (slave).
//
// Handshake rule for every channel here: a transfer happens on a rising clock
// edge where valid and ready are both high. The valid side holds its payload
// stable until that edge. The ready side may change ready on any cycle.
// Channels: ld_addr (kernel->mem), ld_data (mem->kernel), st (kernel->mem),
// st_done (mem->kernel, payload-free token).
interface ldst_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_addr_valid;
    logic              ld_addr_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_data_valid;
    logic              ld_data_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_done_valid;
    logic              st_done_ready;
    logic              init_busy;

    modport master (
        output ld_addr, ld_addr_valid, ld_data_ready,
        output st_addr, st_data, st_valid, st_done_ready,
        input  ld_addr_ready, ld_data, ld_data_valid,
        input  st_ready, st_done_valid, init_busy
    );

    modport slave (
        input  ld_addr, ld_addr_valid, ld_data_ready,
        input  st_addr, st_data, st_valid, st_done_ready,
        output ld_addr_ready, ld_data, ld_data_valid,
        output st_ready, st_done_valid, init_busy
    );
endinterface

// File: rtl/ldst_mem_responder.sv
// Clocked RAM responder for one load port and one store port of a kernel.
// After reset it zeroes the whole RAM (INIT), then serves loads through a
// fixed-latency read pipeline feeding a small response FIFO, and stores with
// a single outstanding completion token.
module ldst_mem_responder #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int LD_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    ldst_mem_responder_if.slave  bus,
    output logic                 dbg_state
);
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int FIFO_D = LD_LATENCY + 1;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   sweep_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // Read pipeline: stage 0 captures the RAM word at the accept edge.
    logic [LD_LATENCY-1:0] pipe_v;
    logic [DATA_W-1:0]     pipe_d [LD_LATENCY];
    logic [2:0]            inflight;

    // Response FIFO (only the first FIFO_D slots are used).
    logic [DATA_W-1:0] fifo_mem [8];
    logic [2:0]        wr_ptr, rd_ptr, fifo_cnt;

    logic done_q;
    logic run, ld_acc, st_acc, done_acc, push, pop;

    function automatic logic [2:0] ptr_next(input logic [2:0] p);
        return (p == 3'(FIFO_D - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    // State register: reset always restarts the zeroing sweep.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    // Next state: leave INIT right after the last address has been zeroed.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && sweep_q == (ADDR_W+1)'(DEPTH - 1))
            state_d = ST_RUN;
    end

    // Outputs and handshake strobes; everything is held off while reset is high.
    always_comb begin
        run               = (state_q == ST_RUN) & ~reset;
        bus.init_busy     = ~run;
        bus.ld_data_valid = run & (fifo_cnt != 3'd0);
        bus.ld_data       = fifo_mem[rd_ptr];
        pop               = bus.ld_data_valid & bus.ld_data_ready;
        // A pop this cycle frees a slot at the same edge, so it counts as a
        // credit; this is what lets a steady stream run at one load per cycle.
        bus.ld_addr_ready = run & (({1'b0, fifo_cnt} + {1'b0, inflight})
                                   < (4'(FIFO_D) + {3'b0, pop}));
        bus.st_ready      = run & ~done_q;
        bus.st_done_valid = run & done_q;
        ld_acc            = bus.ld_addr_valid & bus.ld_addr_ready;
        st_acc            = bus.st_valid & bus.st_ready;
        done_acc          = bus.st_done_valid & bus.st_done_ready;
        push              = pipe_v[LD_LATENCY-1];
        dbg_state         = state_q;
    end

    // Count loads still travelling through the read pipeline.
    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < LD_LATENCY; i++)
            inflight = inflight + {2'b0, pipe_v[i]};
    end

    // Sweep counter walks every address once per INIT.
    always_ff @(posedge clock) begin
        if (reset)                   sweep_q <= '0;
        else if (state_q == ST_INIT) sweep_q <= sweep_q + 1'b1;
    end

    // RAM write port: zeroes during INIT, store data during RUN.
    always_ff @(posedge clock) begin
        if (state_q == ST_INIT)
            mem[sweep_q[ADDR_W-1:0]] <= '0;
        else if (st_acc)
            mem[bus.st_addr] <= bus.st_data;
    end

    // Pipeline valid bits; reset drops every in-flight load.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= ld_acc;
            for (int i = 1; i < LD_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    // Pipeline data; the non-blocking read gives read-before-write on a
    // same-address store in the same cycle.
    always_ff @(posedge clock) begin
        pipe_d[0] <= mem[bus.ld_addr];
        for (int i = 1; i < LD_LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            fifo_cnt <= fifo_cnt + {2'b0, push} - {2'b0, pop};
        end
    end

    // FIFO storage.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= pipe_d[LD_LATENCY-1];
    end

    // Store completion token: at most one outstanding.
    always_ff @(posedge clock) begin
        if (reset)         done_q <= 1'b0;
        else if (st_acc)   done_q <= 1'b1;
        else if (done_acc) done_q <= 1'b0;
    end
endmodule

// File: tb/tb_ldst_mem_responder.sv
// Bench for ldst_mem_responder: directed scenarios plus a random phase, with a
// negedge monitor that keeps a behavioural model (shadow RAM, queue of
// outstanding loads with their due cycle, pending-done flag).
module tb_ldst_mem_responder;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int LAT    = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clock;
  logic reset;
  logic dbg_state;

  ldst_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ldst_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LD_LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int                due_q [$];
  bit  done_pend = 0;
  int  init_left = DEPTH;
  int  mon_cyc = 0;
  int  ld_acc_cnt = 0;
  int  st_acc_cnt = 0;
  int  pop_cnt = 0;
  int  last_ld_acc_cyc = 0;
  int  last_pop_cyc = 0;
  logic [DATA_W-1:0] last_pop_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs to the model, then applies this cycle's
  // transfers to the model. Loads issued at sample n become visible at
  // sample n+LAT+1 (LAT edges after the accept edge).
  bit run_e, exp_ldv, pop_e, exp_ldr;
  always @(negedge clock) begin
    if (reset) begin
      check("rst_init_busy", 32'(bus.init_busy), 32'd1);
      check("rst_ld_data_valid", 32'(bus.ld_data_valid), 32'd0);
      check("rst_st_done_valid", 32'(bus.st_done_valid), 32'd0);
      check("rst_ld_addr_ready", 32'(bus.ld_addr_ready), 32'd0);
      check("rst_st_ready", 32'(bus.st_ready), 32'd0);
      exp_q.delete();
      due_q.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      done_pend = 0;
      init_left = DEPTH;
    end else begin
      run_e   = (init_left == 0);
      exp_ldv = (exp_q.size() > 0) && (due_q[0] <= mon_cyc);
      pop_e   = exp_ldv && bus.ld_data_ready;
      exp_ldr = run_e && ((exp_q.size() - int'(pop_e)) < LAT + 1);
      check("init_busy", 32'(bus.init_busy), 32'(!run_e));
      check("dbg_state", 32'(dbg_state), 32'(run_e));
      check("ld_data_valid", 32'(bus.ld_data_valid), 32'(exp_ldv));
      if (exp_ldv) check("ld_data", bus.ld_data, exp_q[0]);
      check("ld_addr_ready", 32'(bus.ld_addr_ready), 32'(exp_ldr));
      check("st_ready", 32'(bus.st_ready), 32'(run_e && !done_pend));
      check("st_done_valid", 32'(bus.st_done_valid), 32'(done_pend));
      if (pop_e) begin
        last_pop_data = exp_q.pop_front();
        void'(due_q.pop_front());
        pop_cnt++;
        last_pop_cyc = mon_cyc;
      end
      // Load reads the shadow RAM before any same-cycle store lands.
      if (bus.ld_addr_valid && exp_ldr) begin
        exp_q.push_back(model_mem[bus.ld_addr]);
        due_q.push_back(mon_cyc + LAT + 1);
        ld_acc_cnt++;
        last_ld_acc_cyc = mon_cyc;
      end
      if (bus.st_valid && run_e && !done_pend) begin
        model_mem[bus.st_addr] = bus.st_data;
        done_pend = 1;
        st_acc_cnt++;
      end else if (done_pend && bus.st_done_ready) begin
        done_pend = 0;
      end
      if (init_left > 0) init_left--;
    end
    mon_cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a);
    bit ok = 0;
    bus.ld_addr = a;
    bus.ld_addr_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (bus.ld_addr_ready) begin ok = 1; break; end
    end
    tick();
    bus.ld_addr_valid = 1'b0;
    check("ld_accept", 32'(ok), 32'd1);
  endtask

  task automatic do_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit ok = 0;
    bus.st_addr = a;
    bus.st_data = d;
    bus.st_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (bus.st_ready) begin ok = 1; break; end
    end
    tick();
    bus.st_valid = 1'b0;
    check("st_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_pops(input int target);
    for (int i = 0; i < 100 && pop_cnt < target; i++) @(posedge clock);
    #1;
    check("pop_wait", 32'(pop_cnt >= target), 32'd1);
  endtask

  // Counts INIT cycles and any response valids seen meanwhile.
  task automatic measure_init(output int n, output int stale);
    n = 0;
    stale = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      @(negedge clock);
      if (bus.ld_data_valid || bus.st_done_valid) stale++;
      if (!bus.init_busy) break;
      n++;
    end
    tick();
  endtask

  // ---------------- test sequence ----------------
  int n, stale, s0, c0, a, acc_cyc;
  logic [DATA_W-1:0] bp_data [8];
  bit la, sa;

  initial begin
    reset = 1'b1;
    bus.ld_addr = '0; bus.ld_addr_valid = 1'b0; bus.ld_data_ready = 1'b1;
    bus.st_addr = '0; bus.st_data = '0; bus.st_valid = 1'b0; bus.st_done_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Init sweep length, then back-to-back loads of every address read 0.
    measure_init(n, stale);
    check("init_len", 32'(n), 32'(DEPTH));
    s0 = pop_cnt;
    c0 = mon_cyc;
    for (int i = 0; i < DEPTH; i++) do_load(ADDR_W'(i));
    check("tput_cycles", 32'(mon_cyc - c0), 32'(DEPTH));
    wait_pops(s0 + DEPTH);

    // Store/load round trip with exact latency.
    bus.st_done_ready = 1'b0;
    do_store(4'd3, 32'hDEADBEEF);
    @(negedge clock);
    check("rt_done_next_cycle", 32'(bus.st_done_valid), 32'd1);
    tick();
    bus.st_done_ready = 1'b1;
    tick();
    s0 = pop_cnt;
    do_load(4'd3);
    acc_cyc = last_ld_acc_cyc;
    wait_pops(s0 + 1);
    // The accept edge lies between samples acc_cyc and acc_cyc+1.
    check("rt_latency", 32'(last_pop_cyc - (acc_cyc + 1)), 32'(LAT));
    check("rt_data", last_pop_data, 32'hDEADBEEF);

    // Backpressure: distinct data in 0..7, consumer stalled.
    for (int i = 0; i < 8; i++) begin
      bp_data[i] = $urandom;
      do_store(ADDR_W'(i), bp_data[i]);
    end
    tick();
    bus.ld_data_ready = 1'b0;
    s0 = ld_acc_cnt;
    a = 0;
    bus.ld_addr = '0;
    bus.ld_addr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      la = bus.ld_addr_ready;
      tick();
      if (la) a++;
      bus.ld_addr = ADDR_W'(a);
    end
    check("bp_accepted", 32'(ld_acc_cnt - s0), 32'(LAT + 1));
    @(negedge clock);
    check("bp_ready_low", 32'(bus.ld_addr_ready), 32'd0);
    tick();
    s0 = pop_cnt;
    bus.ld_data_ready = 1'b1;
    for (int c = 0; c < 60 && a < 8; c++) begin
      @(negedge clock);
      la = bus.ld_addr_ready;
      tick();
      if (la) a++;
      bus.ld_addr = ADDR_W'(a);
      if (a == 8) bus.ld_addr_valid = 1'b0;
    end
    bus.ld_addr_valid = 1'b0;
    check("bp_all_issued", 32'(a), 32'd8);
    wait_pops(s0 + 8);
    check("bp_last_data", last_pop_data, bp_data[7]);

    // Collision: same-cycle store and load to one address.
    do_store(4'd5, 32'd7);
    tick();
    s0 = pop_cnt;
    bus.ld_addr = 4'd5; bus.ld_addr_valid = 1'b1;
    bus.st_addr = 4'd5; bus.st_data = 32'd9; bus.st_valid = 1'b1;
    @(negedge clock);
    check("col_both_ready", 32'({bus.ld_addr_ready, bus.st_ready}), 32'd3);
    tick();
    bus.ld_addr_valid = 1'b0;
    bus.st_valid = 1'b0;
    wait_pops(s0 + 1);
    check("col_old_data", last_pop_data, 32'd7);
    do_load(4'd5);
    wait_pops(s0 + 2);
    check("col_new_data", last_pop_data, 32'd9);

    // Store throttle: second store waits for the done handshake.
    bus.st_done_ready = 1'b0;
    do_store(4'd10, 32'h0000_00A1);
    bus.st_addr = 4'd11; bus.st_data = 32'h0000_00B2; bus.st_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("thr_st_ready_low", 32'(bus.st_ready), 32'd0);
      check("thr_done_held", 32'(bus.st_done_valid), 32'd1);
      tick();
    end
    bus.st_done_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n++;
      if (bus.st_ready) break;
    end
    tick();
    bus.st_valid = 1'b0;
    check("thr_b_wait", 32'(n), 32'd2);
    tick();

    // Mid-operation reset with loads in flight and a pending done.
    bus.ld_data_ready = 1'b0;
    bus.st_done_ready = 1'b0;
    do_load(4'd1);
    do_load(4'd2);
    do_store(4'd4, 32'h1234_5678);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ld_data_ready = 1'b1;
    bus.st_done_ready = 1'b1;
    measure_init(n, stale);
    check("mid_init_len", 32'(n), 32'(DEPTH));
    check("mid_no_stale", 32'(stale), 32'd0);
    s0 = pop_cnt;
    do_load(4'd4);
    wait_pops(s0 + 1);
    check("mid_rezeroed", last_pop_data, 32'd0);

    // Random traffic with random consumer backpressure.
    for (int c = 0; c < 500; c++) begin
      @(negedge clock);
      la = bus.ld_addr_valid && bus.ld_addr_ready;
      sa = bus.st_valid && bus.st_ready;
      tick();
      if (!bus.ld_addr_valid || la) begin
        bus.ld_addr_valid = ($urandom_range(0, 3) != 0);
        bus.ld_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      end
      if (!bus.st_valid || sa) begin
        bus.st_valid = ($urandom_range(0, 1) != 0);
        bus.st_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        bus.st_data = $urandom;
      end
      bus.ld_data_ready = ($urandom_range(0, 3) != 0);
      bus.st_done_ready = ($urandom_range(0, 1) != 0);
    end
    // Drop valids only once the current offer has been taken.
    for (int c = 0; c < 20 && (bus.ld_addr_valid || bus.st_valid); c++) begin
      @(negedge clock);
      la = bus.ld_addr_valid && bus.ld_addr_ready;
      sa = bus.st_valid && bus.st_ready;
      bus.ld_data_ready = 1'b1;
      bus.st_done_ready = 1'b1;
      tick();
      if (la) bus.ld_addr_valid = 1'b0;
      if (sa) bus.st_valid = 1'b0;
    end
    bus.ld_addr_valid = 1'b0;
    bus.st_valid = 1'b0;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
